// File: rtl/btn_pkg.sv
// Shared constants for the push-button front end: channel indices,
// repeat-FSM state encoding and counter-width helpers.
package btn_pkg;

    localparam int N_BTN  = 9;

    localparam int BTN_P  = 0;
    localparam int BTN_R  = 1;
    localparam int BTN_L  = 2;
    localparam int BTN_U  = 3;
    localparam int BTN_D  = 4;
    localparam int BTN_F  = 5;
    localparam int BTN_T  = 6;
    localparam int BTN_S0 = 7;
    localparam int BTN_S1 = 8;

    localparam logic [1:0] RPT_IDLE_ENC   = 2'b00;
    localparam logic [1:0] RPT_HOLD_ENC   = 2'b01;
    localparam logic [1:0] RPT_REPEAT_ENC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = RPT_IDLE_ENC,
        ST_HOLD   = RPT_HOLD_ENC,
        ST_REPEAT = RPT_REPEAT_ENC
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A terminal count of 1 would give a zero-width counter; keep at least one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button channel: 2-FF synchronizer, restart-on-glitch debounce filter,
// and a rise strobe that is high in the cycle before level goes 0->1.
module debounce_cell
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int                CNT_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    assign flip = (s2 != level) && (cnt == CNT_TC);

    // Combinational so the top can register its pulse on the same edge level rises.
    assign rise = flip && s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw push-buttons into debounced levels and one-cycle press
// pulses, with auto-repeat on the masked channels (scroll buttons U/D).
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | button released, waiting for a debounced press
//  ST_HOLD   | pressed, counting REPEAT_DELAY before the first repeat tick
//  ST_REPEAT | repeating, one tick every REPEAT_PERIOD cycles
module button_conditioner
    import btn_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 1_000_000,
    parameter int               REPEAT_DELAY    = 50_000_000,
    parameter int               REPEAT_PERIOD   = 20_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 9'b000011000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam int                RCNT_W  = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RCNT_W-1:0] DLY_TC  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PER_TC  = RCNT_W'(REPEAT_PERIOD - 1);

    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] rise_q;
    logic [N_BTN-1:0] tick_q;
    logic             ud_conflict;

    // Holding both scroll directions at once is ambiguous, so neither repeats.
    assign ud_conflict = btn_level[BTN_U] & btn_level[BTN_D];

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[g]),
            .level(btn_level[g]),
            .rise (rise[g])
        );

        if (REPEAT_MASK[g]) begin : g_rpt
            localparam bit IS_UD = (g == BTN_U) || (g == BTN_D);

            rpt_state_t        state;
            logic [RCNT_W-1:0] rcnt;
            logic              tick;
            logic              hold_off;

            assign hold_off  = IS_UD && ud_conflict;
            assign tick_q[g] = tick;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state <= ST_IDLE;
                    rcnt  <= '0;
                    tick  <= 1'b0;
                end else begin
                    tick <= 1'b0;
                    case (state)
                        ST_IDLE: begin
                            rcnt <= '0;
                            if (rise[g]) state <= ST_HOLD;
                        end
                        ST_HOLD: begin
                            if (!btn_level[g]) begin
                                state <= ST_IDLE;
                                rcnt  <= '0;
                            end else if (hold_off) begin
                                rcnt  <= '0;
                            end else if (rcnt == DLY_TC) begin
                                tick  <= 1'b1;
                                rcnt  <= '0;
                                state <= ST_REPEAT;
                            end else begin
                                rcnt  <= rcnt + RCNT_W'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (!btn_level[g]) begin
                                state <= ST_IDLE;
                                rcnt  <= '0;
                            end else if (hold_off) begin
                                state <= ST_HOLD;
                                rcnt  <= '0;
                            end else if (rcnt == PER_TC) begin
                                tick  <= 1'b1;
                                rcnt  <= '0;
                            end else begin
                                rcnt  <= rcnt + RCNT_W'(1);
                            end
                        end
                        default: begin
                            state <= ST_IDLE;
                            rcnt  <= '0;
                        end
                    endcase
                end
            end
        end else begin : g_no_rpt
            assign tick_q[g] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q <= '0;
        end else begin
            rise_q <= rise;
        end
    end

    // Both terms are registers; a press edge and a repeat tick can never coincide.
    assign btn_pulse = rise_q | tick_q;

endmodule
